// File: rtl/counter_8bit_checker_pkg.sv
// Shared definitions for the 8-bit up-counter checker.
//   chk_state_e     : checker state (IDLE, ACQ, TRACK, FAIL)
//   KIND_*_BIT      : bit positions inside mismatch_kind
//   CNT_W, ALL_ONES : default counter width and its all-ones value
package counter_8bit_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK,
        ST_FAIL
    } chk_state_e;

    localparam int unsigned KIND_COUNT_BIT = 0;
    localparam int unsigned KIND_COMB_BIT  = 1;

    localparam int unsigned       CNT_W    = 8;
    localparam logic [CNT_W-1:0]  ALL_ONES = '1;

endpackage

// File: rtl/counter_8bit_checker_sat_cnt.sv
// Saturating up-counter used for the error and wrap totals.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the count
//   inc    : increment request for this edge
//   count  : current total, sticks at all-ones
module counter_8bit_checker_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/counter_8bit_checker.sv
// Reader-side checker for the 8-bit up-counter: predicts the DUT count from
// its sampled enable/async_set inputs, flags count and comb_out mismatches,
// totals errors and wraps, and captures the first failure.
// Ports:
//   clk, async_reset_n       : shared clock, async active-low reset
//   check_en                 : 1 = check, 0 = return to IDLE
//   dut_count/enable/async_set/comb_out : sampled DUT signals
//   locked                   : high while tracking
//   mismatch, mismatch_kind  : one-cycle error pulse, {comb_err, count_err}
//   err_count, wrap_count    : saturating totals
//   first_exp, first_obs     : expected/observed count at the first error
//   fail                     : high in FAIL (STOP_ON_ERR = 1 only)
module counter_8bit_checker
    import counter_8bit_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_W,
    parameter int unsigned ERR_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             check_en,
    input  logic [WIDTH-1:0] dut_count,
    input  logic             dut_enable,
    input  logic             dut_async_set,
    input  logic             dut_comb_out,
    output logic             locked,
    output logic             mismatch,
    output logic [1:0]       mismatch_kind,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic             fail
);

    chk_state_e       state;
    logic [WIDTH-1:0] exp_cnt;
    logic [WIDTH-1:0] exp_now;
    logic [WIDTH-1:0] exp_next;
    logic [WIDTH-1:0] resync_val;
    logic             comb_exp;
    logic             cnt_err;
    logic             comb_err;
    logic             in_track;
    logic             err_inc;
    logic             wrap_inc;
    logic             first_armed;

    // Reference model for the current edge
    always_comb begin
        exp_now    = dut_async_set ? '1 : exp_cnt;
        comb_exp   = dut_async_set & dut_enable;
        exp_next   = dut_async_set ? '1 : exp_now + WIDTH'(dut_enable);
        // Realign to what the DUT actually shows (used by ACQ and resync)
        resync_val = dut_async_set ? '1 : dut_count + WIDTH'(dut_enable);
        in_track   = check_en && (state == ST_TRACK);
        cnt_err    = (dut_count != exp_now);
        comb_err   = (dut_comb_out != comb_exp);
        err_inc    = in_track && (cnt_err || comb_err);
        wrap_inc   = in_track && (exp_now == '1) && dut_enable && !dut_async_set;
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state         <= ST_IDLE;
            exp_cnt       <= '0;
            locked        <= 1'b0;
            mismatch      <= 1'b0;
            mismatch_kind <= '0;
            first_exp     <= '0;
            first_obs     <= '0;
            fail          <= 1'b0;
            first_armed   <= 1'b1;
        end else begin
            mismatch      <= 1'b0;
            mismatch_kind <= '0;
            if (!check_en) begin
                // Totals and first_* are kept; only the capture re-arms
                state       <= ST_IDLE;
                locked      <= 1'b0;
                fail        <= 1'b0;
                first_armed <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ACQ;
                    ST_ACQ: begin
                        exp_cnt <= resync_val;
                        state   <= ST_TRACK;
                        locked  <= 1'b1;
                    end
                    ST_TRACK: begin
                        if (err_inc) begin
                            mismatch                      <= 1'b1;
                            mismatch_kind[KIND_COUNT_BIT] <= cnt_err;
                            mismatch_kind[KIND_COMB_BIT]  <= comb_err;
                            if (first_armed) begin
                                first_exp   <= exp_now;
                                first_obs   <= dut_count;
                                first_armed <= 1'b0;
                            end
                            if (STOP_ON_ERR) begin
                                // exp_cnt stays frozen at the failing point
                                state  <= ST_FAIL;
                                fail   <= 1'b1;
                                locked <= 1'b0;
                            end else begin
                                exp_cnt <= resync_val;
                            end
                        end else begin
                            exp_cnt <= exp_next;
                        end
                    end
                    ST_FAIL: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    counter_8bit_checker_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (async_reset_n),
        .inc   (err_inc),
        .count (err_count)
    );

    counter_8bit_checker_sat_cnt #(.W(ERR_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (async_reset_n),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

endmodule

// File: tb/tb_counter_8bit_checker.sv
// Bench for counter_8bit_checker: drives a behavioural 8-bit counter (with
// fault injection) into two checkers (resync and stop-on-error) and compares
// every cycle against an arithmetic model of the checker rules.
module tb_counter_8bit_checker;

    typedef struct packed {
        int st;      // 0 idle, 1 acquire, 2 tracking, 3 failed
        int expv;
        int locked;
        int fail;
        int mis;
        int kind;
        int err;
        int wrap;
        int fe;
        int fo;
        int armed;
    } model_t;

    logic       clk = 1'b0;
    logic       async_reset_n = 1'b0;
    logic       check_en = 1'b0;
    logic       set = 1'b0;
    logic       en = 1'b0;
    logic       inj_on = 1'b0;
    logic [7:0] inj_val = 8'h00;
    logic       comb_force = 1'b0;
    logic       comb_val = 1'b0;
    logic [7:0] ctr = 8'h00;
    logic [7:0] dut_count;
    logic       dut_comb_out;

    logic       d0_locked, d0_mis, d0_fail, d1_locked, d1_mis, d1_fail;
    logic [1:0] d0_kind, d1_kind;
    logic [7:0] d0_err, d0_wrap, d0_fe, d0_fo, d1_err, d1_wrap, d1_fe, d1_fo;

    model_t m0, m1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Counter under test: async_set forces all-ones, injection overrides value
    assign dut_count    = inj_on ? inj_val : (set ? 8'hFF : ctr);
    assign dut_comb_out = comb_force ? comb_val : (set & en);
    always @(posedge clk) ctr <= set ? 8'hFF : (inj_on ? inj_val : ctr) + {7'b0, en};

    counter_8bit_checker #(.WIDTH(8), .ERR_W(8), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .async_reset_n(async_reset_n), .check_en(check_en),
        .dut_count(dut_count), .dut_enable(en), .dut_async_set(set),
        .dut_comb_out(dut_comb_out), .locked(d0_locked), .mismatch(d0_mis),
        .mismatch_kind(d0_kind), .err_count(d0_err), .wrap_count(d0_wrap),
        .first_exp(d0_fe), .first_obs(d0_fo), .fail(d0_fail));

    counter_8bit_checker #(.WIDTH(8), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .async_reset_n(async_reset_n), .check_en(check_en),
        .dut_count(dut_count), .dut_enable(en), .dut_async_set(set),
        .dut_comb_out(dut_comb_out), .locked(d1_locked), .mismatch(d1_mis),
        .mismatch_kind(d1_kind), .err_count(d1_err), .wrap_count(d1_wrap),
        .first_exp(d1_fe), .first_obs(d1_fo), .fail(d1_fail));

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.armed = 1;
        return r;
    endfunction

    function automatic model_t step(model_t m, bit stop, bit ce, bit s, bit e, int cnt, bit comb);
        model_t n;
        int now;
        bit cerr, kerr;
        n = m;
        n.mis = 0;
        n.kind = 0;
        if (!ce) begin
            n.st = 0; n.locked = 0; n.fail = 0; n.armed = 1;
            return n;
        end
        case (m.st)
            0: n.st = 1;
            1: begin
                n.expv = s ? 255 : (cnt + int'(e)) % 256;
                n.st = 2;
                n.locked = 1;
            end
            2: begin
                now  = s ? 255 : m.expv;
                cerr = (cnt != now);
                kerr = (comb != (s & e));
                if (now == 255 && e && !s && n.wrap < 255) n.wrap++;
                if (cerr || kerr) begin
                    n.mis = 1;
                    n.kind = 2 * int'(kerr) + int'(cerr);
                    if (n.err < 255) n.err++;
                    if (m.armed != 0) begin
                        n.fe = now; n.fo = cnt; n.armed = 0;
                    end
                    if (stop) begin
                        n.st = 3; n.fail = 1; n.locked = 0;
                    end else begin
                        n.expv = s ? 255 : (cnt + int'(e)) % 256;
                    end
                end else begin
                    n.expv = s ? 255 : (now + int'(e)) % 256;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= step(m0, 1'b0, check_en, set, en, int'(dut_count), dut_comb_out);
            m1 <= step(m1, 1'b1, check_en, set, en, int'(dut_count), dut_comb_out);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
            miscompares++;
        end
    endtask

    task automatic pin(input string name, input int act, input int exp);
        vectors++;
        check(name, act, exp);
    endtask

    task automatic compare_all();
        vectors++;
        check("d0.locked", d0_locked, m0.locked);
        check("d0.mismatch", d0_mis, m0.mis);
        check("d0.kind", d0_kind, m0.kind);
        check("d0.err", d0_err, m0.err);
        check("d0.wrap", d0_wrap, m0.wrap);
        check("d0.first_exp", d0_fe, m0.fe);
        check("d0.first_obs", d0_fo, m0.fo);
        check("d0.fail", d0_fail, m0.fail);
        check("d1.locked", d1_locked, m1.locked);
        check("d1.mismatch", d1_mis, m1.mis);
        check("d1.kind", d1_kind, m1.kind);
        check("d1.err", d1_err, m1.err);
        check("d1.wrap", d1_wrap, m1.wrap);
        check("d1.first_exp", d1_fe, m1.fe);
        check("d1.first_obs", d1_fo, m1.fo);
        check("d1.fail", d1_fail, m1.fail);
    endtask

    // Compare on the falling edge, then move inputs clear of both edges
    task automatic tick();
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic all_zero(input string tag);
        pin({tag, ".d0"}, int'(d0_locked) + int'(d0_mis) + int'(d0_kind) + int'(d0_err)
            + int'(d0_wrap) + int'(d0_fe) + int'(d0_fo) + int'(d0_fail), 0);
        pin({tag, ".d1"}, int'(d1_locked) + int'(d1_mis) + int'(d1_kind) + int'(d1_err)
            + int'(d1_wrap) + int'(d1_fe) + int'(d1_fo) + int'(d1_fail), 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        all_zero("reset");
        async_reset_n = 1'b1;

        // Lock with async_set held, then 300 enabled cycles
        check_en = 1'b1; set = 1'b1; en = 1'b1;
        tick();
        pin("lock_1cyc", d0_locked, 0);
        tick();
        pin("lock_2cyc", d0_locked, 1);
        tick();
        set = 1'b0;
        repeat (300) tick();
        pin("wrap_300", d0_wrap, 2);
        pin("err_clean", d0_err, 0);
        pin("d1_err_clean", d1_err, 0);

        // Hold async_set, release without enable, then count
        set = 1'b1; en = 1'b1;
        repeat (5) tick();
        set = 1'b0; en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (3) tick();
        pin("set_hold_err", d0_err, 0);

        // Count error: show 0x12 where 0x11 is due
        n = 0;
        while (ctr != 8'h11 && n < 300) begin
            tick();
            n++;
        end
        pin("reach_0x11", int'(ctr), 8'h11);
        inj_on = 1'b1; inj_val = 8'h12;
        tick();
        inj_on = 1'b0;
        pin("inj.mismatch", d0_mis, 1);
        pin("inj.kind", d0_kind, 1);
        pin("inj.first_exp", d0_fe, 8'h11);
        pin("inj.first_obs", d0_fo, 8'h12);
        pin("inj.err", d0_err, 1);
        pin("stop.fail", d1_fail, 1);
        pin("stop.locked", d1_locked, 0);
        repeat (3) tick();
        pin("resync.err", d0_err, 1);
        inj_on = 1'b1; inj_val = ctr + 8'd5;
        tick();
        inj_on = 1'b0;
        pin("stop.err_held", d1_err, 1);
        pin("resync.err2", d0_err, 2);
        pin("first_exp_held", d0_fe, 8'h11);

        // Drop check_en for one cycle and relock
        check_en = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        pin("relock_1cyc", d1_locked, 0);
        tick();
        pin("relock_2cyc", d1_locked, 1);
        pin("relock_fail", d1_fail, 0);
        repeat (2) tick();

        // comb_out error during async_set, then count+comb together
        set = 1'b1; en = 1'b1; comb_force = 1'b1; comb_val = 1'b0;
        tick();
        comb_force = 1'b0; set = 1'b0;
        pin("comb.kind", d0_kind, 2);
        pin("comb.err", d0_err, 3);
        repeat (3) tick();
        inj_on = 1'b1; inj_val = ctr + 8'd3; comb_force = 1'b1; comb_val = 1'b1;
        tick();
        inj_on = 1'b0; comb_force = 1'b0;
        pin("both.kind", d0_kind, 3);
        pin("both.err", d0_err, 4);
        pin("both.d1_err", d1_err, 2);
        repeat (2) tick();

        // Saturate err_count
        comb_force = 1'b1; comb_val = 1'b1;
        repeat (260) tick();
        comb_force = 1'b0;
        pin("sat.err", d0_err, 255);
        repeat (5) tick();

        // Asynchronous reset mid-track
        #2 async_reset_n = 1'b0;
        #1 all_zero("async_rst");
        tick();
        async_reset_n = 1'b1;
        repeat (10) tick();
        pin("post_rst.locked", d0_locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
